// File: rtl/ls_down_divider.sv
// Loadable down-counter / frequency divider with a one-shot or auto-reload
// mode, a registered expiry pulse and a combinational borrow lookahead.
module ls_down_divider #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             MODE,
    output logic [WIDTH-1:0] Q,
    output logic             ZP,
    output logic             BO,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             zp_reg, zp_next;
    logic             busy_reg;

    // Next-state, next-count and expiry-pulse decode: load beats counting.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        q_next     = q_reg;
        r_next     = r_reg;
        zp_next    = 1'b0;

        if (!LOAD_n) begin
            r_next     = D;
            q_next     = D;
            state_next = (D != '0) ? RUN : IDLE;
        end else if (state == RUN && ENP && ENT) begin
            if (q_reg > ONE) begin
                q_next = q_reg - ONE;
            end else if (q_reg == ONE) begin
                // Expiry edge: the only place MODE is looked at.
                zp_next = 1'b1;
                if (MODE) begin
                    q_next = r_reg;
                end else begin
                    q_next     = '0;
                    state_next = DONE;
                end
            end
            // A zero count in RUN cannot be reached; it simply holds, so
            // the counter never wraps below zero.
        end
    end

    // State, count, reload and pulse registers; CLR clears them at once.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state    <= IDLE;
            q_reg    <= '0;
            r_reg    <= '0;
            zp_reg   <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_next;
            q_reg    <= q_next;
            r_reg    <= r_next;
            zp_reg   <= zp_next;
            busy_reg <= (state_next == RUN);
        end
    end

    assign Q    = q_reg;
    assign ZP   = zp_reg;
    assign BUSY = busy_reg;
    // Borrow lookahead is purely combinational so it can be cascaded
    // into the next stage's ENT within the same cycle.
    assign BO   = ENT && (q_reg == ONE) && (state == RUN);

endmodule

// File: tb/tb_ls_down_divider.sv
// Self-checking bench for ls_down_divider: a behavioural reference model
// pushes expected register values into a scoreboard queue at each edge,
// and they are popped and compared once the DUT has updated.
module tb_ls_down_divider;

    localparam int WIDTH = 8;

    logic             CLK = 1'b0;
    logic             CLR;
    logic [WIDTH-1:0] D;
    logic             LOAD_n;
    logic             ENP;
    logic             ENT;
    logic             MODE;
    logic [WIDTH-1:0] Q;
    logic             ZP;
    logic             BO;
    logic             BUSY;

    ls_down_divider #(.WIDTH(WIDTH)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .D      (D),
        .LOAD_n (LOAD_n),
        .ENP    (ENP),
        .ENT    (ENT),
        .MODE   (MODE),
        .Q      (Q),
        .ZP     (ZP),
        .BO     (BO),
        .BUSY   (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int q;
        int zp;
        int busy;
    } exp_t;

    exp_t sb[$];

    int n_err = 0;
    int n_chk = 0;

    // Reference model state: 0 = IDLE, 1 = RUN, 2 = DONE.
    int m_q;
    int m_r;
    int m_zp;
    int m_state;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0;
        m_r = 0;
        m_zp = 0;
        m_state = 0;
    endtask

    task automatic model_step();
        if (!LOAD_n) begin
            m_r = int'(D);
            m_q = int'(D);
            m_zp = 0;
            m_state = (D != 0) ? 1 : 0;
        end else begin
            m_zp = 0;
            if (m_state == 1 && ENP && ENT) begin
                if (m_q > 1) begin
                    m_q = m_q - 1;
                end else if (m_q == 1) begin
                    m_zp = 1;
                    if (MODE) begin
                        m_q = m_r;
                    end else begin
                        m_q = 0;
                        m_state = 2;
                    end
                end
            end
        end
    endtask

    // One clock: check BO before the edge, predict, then compare after it.
    // A non-negative lit_q also checks Q against a hand-derived value.
    task automatic cycle(input string tag, input int lit_q = -1);
        exp_t e;
        #1;
        check({tag, ".bo"}, int'(BO), (ENT && m_q == 1 && m_state == 1) ? 1 : 0);
        model_step();
        e.q = m_q;
        e.zp = m_zp;
        e.busy = (m_state == 1) ? 1 : 0;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check({tag, ".q"}, int'(Q), e.q);
        check({tag, ".zp"}, int'(ZP), e.zp);
        check({tag, ".busy"}, int'(BUSY), e.busy);
        if (lit_q >= 0) check({tag, ".qlit"}, int'(Q), lit_q);
        @(negedge CLK);
    endtask

    task automatic load(input string tag, input int val, input logic md);
        LOAD_n = 1'b0;
        D = WIDTH'(val);
        MODE = md;
        cycle(tag, val);
        LOAD_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        CLR = 1'b1;
        D = '0;
        LOAD_n = 1'b1;
        ENP = 1'b1;
        ENT = 1'b1;
        MODE = 1'b1;
        model_reset();
        #1;
        check("rst.q", int'(Q), 0);
        check("rst.zp", int'(ZP), 0);
        check("rst.busy", int'(BUSY), 0);
        check("rst.bo", int'(BO), 0);
        @(negedge CLK);
        @(negedge CLK);
        CLR = 1'b0;

        // Auto-reload divide by 3; MODE toggled away from expiry is ignored.
        load("t1.load", 3, 1'b1);
        cycle("t1.c1", 2);
        cycle("t1.c2", 1);
        cycle("t1.c3", 3);
        check("t1.zp_on_reload", int'(ZP), 1);
        MODE = 1'b0;
        cycle("t1.c4", 2);
        MODE = 1'b1;
        cycle("t1.c5", 1);
        cycle("t1.c6", 3);
        check("t1.zp_on_reload2", int'(ZP), 1);
        cycle("t1.c7", 2);

        // One-shot: 2,1,0 then parked in DONE.
        load("t2.load", 2, 1'b0);
        cycle("t2.c1", 1);
        cycle("t2.c2", 0);
        check("t2.zp_expire", int'(ZP), 1);
        check("t2.busy_fall", int'(BUSY), 0);
        for (int i = 0; i < 10; i++) cycle("t2.hold", 0);

        // Enable gating: ENP and ENT each stall the count.
        load("t3.load", 5, 1'b0);
        cycle("t3.c1", 4);
        cycle("t3.c2", 3);
        ENP = 1'b0;
        cycle("t3.enp0a", 3);
        cycle("t3.enp0b", 3);
        ENP = 1'b1;
        ENT = 1'b0;
        cycle("t3.ent0", 3);
        ENT = 1'b1;
        cycle("t3.c3", 2);
        cycle("t3.c4", 1);
        ENT = 1'b0;
        cycle("t3.q1_ent0", 1);
        ENT = 1'b1;
        ENP = 1'b0;
        cycle("t3.q1_enp0", 1);
        ENP = 1'b1;
        cycle("t3.c5", 0);

        // Load wins over expiry on the same edge.
        load("t4.load", 2, 1'b1);
        cycle("t4.c1", 1);
        LOAD_n = 1'b0;
        D = WIDTH'(7);
        cycle("t4.load_at_1", 7);
        LOAD_n = 1'b1;
        check("t4.zp", int'(ZP), 0);
        check("t4.busy", int'(BUSY), 1);

        // Asynchronous clear in the middle of a count.
        load("t5.load", 6, 1'b1);
        cycle("t5.c1", 5);
        cycle("t5.c2", 4);
        #2;
        CLR = 1'b1;
        #1;
        check("t5.clr.q", int'(Q), 0);
        check("t5.clr.busy", int'(BUSY), 0);
        check("t5.clr.bo", int'(BO), 0);
        #1;
        CLR = 1'b0;
        model_reset();
        @(negedge CLK);
        for (int i = 0; i < 4; i++) cycle("t5.after", 0);

        // Zero load parks in IDLE; divide-by-1 pulses every cycle.
        load("t6.load0", 0, 1'b1);
        check("t6.busy0", int'(BUSY), 0);
        for (int i = 0; i < 3; i++) cycle("t6.idle", 0);
        load("t6.load1", 1, 1'b1);
        check("t6.zp_first", int'(ZP), 0);
        for (int i = 0; i < 4; i++) begin
            cycle("t6.div1", 1);
            check("t6.div1.zp", int'(ZP), 1);
        end

        if (sb.size() != 0) check("sb.empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ls_down_divider.md
LS_DOWN_DIVIDER -- requirements
Module: ls_down_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and data width in bits (legal range 2..16).
REQ-002 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port CLR  input  1  reset; one clock, asynchronous, active-high.
REQ-004 SHALL have port D  input  WIDTH  parallel reload value.
REQ-005 SHALL have port LOAD_n  input  1  synchronous active-low parallel load.
REQ-006 SHALL have port ENP  input  1  count enable, parallel.
REQ-007 SHALL have port ENT  input  1  count enable, trickle; also gates BO.
REQ-008 SHALL have port MODE  input  1  0 = one-shot, 1 = auto-reload (periodic divide).
REQ-009 SHALL have port Q  output  WIDTH  registered count value.
REQ-010 SHALL have port ZP  output  1  registered one-cycle terminal (expiry) pulse.
REQ-011 SHALL have port BO  output  1  combinational borrow lookahead.
REQ-012 SHALL have port BUSY  output  1  registered; high while in RUN.

Function
REQ-013 SHALL hold an internal reload register R (WIDTH bits) and a state machine with states IDLE, RUN, DONE.
REQ-014 Priority per rising edge SHALL be: CLR > LOAD_n > count.
REQ-015 LOAD_n=0 in any state SHALL set R<=D, Q<=D, ZP<=0, regardless of ENP/ENT/MODE.
REQ-016 On load with D!=0, state SHALL go to RUN; with D==0, state SHALL go to IDLE.
REQ-017 In RUN with LOAD_n=1 and ENP=ENT=1 and Q>1: Q<=Q-1, ZP<=0.
REQ-018 In RUN with LOAD_n=1, ENP=ENT=1, Q==1, MODE=1: Q<=R, ZP<=1, state stays RUN (period = R cycles).
REQ-019 In RUN with LOAD_n=1, ENP=ENT=1, Q==1, MODE=0: Q<=0, ZP<=1, state<=DONE.
REQ-020 In RUN with ENP=0 or ENT=0 (and LOAD_n=1): Q, R and state SHALL hold; ZP<=0.
REQ-021 MODE SHALL be sampled only on the expiry edge (Q==1 with enables high); changes elsewhere have no effect.
REQ-022 In IDLE and DONE with LOAD_n=1: Q, R and state SHALL hold; ZP<=0; enables ignored.
REQ-023 Q SHALL never decrement through zero; no underflow wrap occurs in any state.
REQ-024 ZP SHALL be high for exactly one cycle per expiry; consecutive pulses allowed only when R==1 and MODE=1.
REQ-025 BO SHALL equal ENT AND (Q==1) AND (state==RUN), combinational, independent of ENP and LOAD_n.
REQ-026 BUSY SHALL be 1 iff state==RUN, registered with the state.

Reset
REQ-027 CLR=1 SHALL immediately (without CLK) force Q=0, R=0, ZP=0, BUSY=0, state=IDLE; BO therefore 0.
REQ-028 While CLR=1 all inputs SHALL be ignored; first active edge after CLR falls follows REQ-014..022 from IDLE.
REQ-029 CLR asserted mid-RUN SHALL abort the count; no ZP pulse is generated by the abort.

Verification
REQ-030 Bench SHALL cover: WIDTH=8, reset, LOAD_n=0 D=3 MODE=1, then ENP=ENT=1 -> Q 3,2,1,3,2,1,...; ZP=1 on each cycle Q returns to 3; BO=1 whenever Q==1.
REQ-031 Bench SHALL cover: load D=2 MODE=0, enables high -> Q 2,1,0; ZP one cycle with Q=0; BUSY falls same edge; Q stays 0 for 10 further cycles, no ZP.
REQ-032 Bench SHALL cover: load D=5, count to Q=3, ENP=0 two cycles -> Q holds 3, ZP=0; ENT=0 one cycle -> Q holds, BO=0; re-enable -> Q 2,1,...
REQ-033 Bench SHALL cover: Q==1 with enables high and LOAD_n=0 D=7 same edge -> Q=7, ZP=0, BUSY=1.
REQ-034 Bench SHALL cover: CLR pulsed between edges during RUN at Q=4 -> Q=0, BUSY=0 before next edge; no ZP thereafter until reload.
REQ-035 Bench SHALL cover: load D=0 -> IDLE, Q=0, no ZP; load D=1 MODE=1 enables high -> Q stays 1, ZP=1 every cycle from second edge on.
